rom_boot_sequencer: RTL and testbench
=====================================

ROM_BOOT_SEQUENCER -- requirements
Module: rom_boot_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the instruction word width.
REQ-002 SHALL have parameter WORD_COUNT, default 40, the number of words per load session (0..65535).
REQ-003 SHALL have parameter SCK_HALF, default 2, the clk cycles per rom_loader_sck phase (>=1).
REQ-004 SHALL have parameter ACK_TIMEOUT, default 1024, the clk cycles to wait for ack before error.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port start, input, 1, a one-cycle request to begin a load session.
REQ-008 SHALL have port in_valid, input, 1, source word valid.
REQ-009 SHALL have port in_data, input, DATA_WIDTH, source word.
REQ-010 SHALL have port in_ready, output, 1, word accepted when in_valid&&in_ready.
REQ-011 SHALL have port rom_loader_load, output, 1, high for the whole session.
REQ-012 SHALL have port rom_loader_sck, output, 1, the word strobe to the SoC loader.
REQ-013 SHALL have port rom_loader_data, output, DATA_WIDTH, the held word.
REQ-014 SHALL have port rom_loader_ack, input, 1, the SoC word-written acknowledge.
REQ-015 SHALL have port hack_external_reset, output, 1, CPU hold; high until load succeeds.
REQ-016 SHALL have port done, output, 1, level; session completed.
REQ-017 SHALL have port error, output, 1, level; ack timeout occurred.
REQ-018 SHALL have port word_cnt, output, 16, words acknowledged this session.

Function
REQ-019 SHALL implement states IDLE, FETCH, SCK_HI, SCK_LO, WAIT_ACK, ACK_LOW, DONE, ERROR.
REQ-020 SHALL move IDLE/DONE/ERROR -> FETCH on start, clear word_cnt, done and error, and assert hack_external_reset and rom_loader_load in the same cycle; start in any other state is ignored.
REQ-021 SHALL move directly to DONE on start when WORD_COUNT==0, never asserting rom_loader_sck.
REQ-022 SHALL drive in_ready high only in FETCH; on handshake, latch in_data into rom_loader_data and enter SCK_HI next cycle.
REQ-023 SHALL hold rom_loader_sck high for exactly SCK_HALF cycles in SCK_HI, then low for SCK_HALF cycles in SCK_LO; rom_loader_data is stable from latch until ack.
REQ-024 SHALL wait in WAIT_ACK for rom_loader_ack==1, then in ACK_LOW for rom_loader_ack==0, before counting the word.
REQ-025 SHALL increment word_cnt on leaving ACK_LOW; the next state is FETCH if word_cnt+1<WORD_COUNT, otherwise DONE.
REQ-026 SHALL enter ERROR when WAIT_ACK or ACK_LOW persists ACK_TIMEOUT cycles; the timer restarts on each state entry.
REQ-027 SHALL deassert rom_loader_load on entry to DONE and deassert hack_external_reset exactly one cycle later; done rises with DONE.
REQ-028 SHALL in ERROR drop rom_loader_load and rom_loader_sck, keep hack_external_reset high, and assert error.
REQ-029 SHALL not time out in FETCH; source stalls wait indefinitely.
REQ-030 SHALL count word_cnt in 16 bits without wrap (WORD_COUNT caps it).

Reset
REQ-031 SHALL on reset asynchronously force IDLE, in_ready=0, rom_loader_load=0, rom_loader_sck=0, rom_loader_data=0, hack_external_reset=1, done=0, error=0, word_cnt=0, including mid-session.
REQ-032 SHALL resume only on a new start after reset release.

Structure
REQ-033 SHALL place the state enum and parameter defaults in shared package hack_rom_loader_pkg.
REQ-034 SHALL use one sub-module, rom_boot_timer, a loadable down-counter serving both SCK phases and the ack timeout.

Verification
REQ-035 SHALL cover start with WORD_COUNT=3 words 0x1234,0xABCD,0x0000 and an ack model of 2-cycle delay -> three sck pulses each 2 hi/2 lo, data matches, word_cnt=3, done=1, hack_external_reset falls one cycle after load falls.
REQ-036 SHALL cover in_valid gaps of 10 cycles between words -> in_ready held, no sck, no error.
REQ-037 SHALL cover ack stuck low with ACK_TIMEOUT=16 -> ERROR 16 cycles after WAIT_ACK entry, error=1, load=0, hack_external_reset=1, word_cnt=0.
REQ-038 SHALL cover reset asserted during SCK_HI of word 2 -> all outputs at reset values in the same cycle; a new start reloads from word_cnt=0.
REQ-039 SHALL cover start pulsed during WAIT_ACK -> ignored, with the session completing normally.
REQ-040 SHALL cover WORD_COUNT=0 with start -> done=1 with no sck edge and hack_external_reset low two cycles after start.

Source files
------------

// File: rtl/hack_rom_loader_pkg.sv
// Shared definitions for the boot ROM loader: parameter defaults, FSM states
// and the timer reload helper used by the sequencer.
package hack_rom_loader_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 16;
    localparam int DEFAULT_WORD_COUNT  = 40;
    localparam int DEFAULT_SCK_HALF    = 2;
    localparam int DEFAULT_ACK_TIMEOUT = 1024;

    // Timer width bounds both SCK_HALF and ACK_TIMEOUT to 65536 cycles.
    localparam int TIMER_WIDTH = 16;
    localparam int COUNT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SCK_HI,
        SCK_LO,
        WAIT_ACK,
        ACK_LOW,
        DONE,
        ERROR
    } boot_state_t;

    // The timer expires when it reaches zero, so a phase of N cycles loads N-1.
    function automatic logic [TIMER_WIDTH-1:0] reload_value(input int cycles);
        return (cycles > 0) ? TIMER_WIDTH'(cycles - 1) : '0;
    endfunction

endpackage

// File: rtl/rom_boot_timer.sv
// Loadable down-counter shared by the two strobe phases and the ack timeout.
// The count saturates at zero and 'expired' is high while it sits there.
module rom_boot_timer
    import hack_rom_loader_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Reload on request, otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/rom_boot_sequencer.sv
// Streams WORD_COUNT words from a valid/ready source into the SoC ROM loader,
// one strobe and one ack handshake per word, holding the CPU in reset until
// the whole image has been written.
module rom_boot_sequencer
    import hack_rom_loader_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int WORD_COUNT  = DEFAULT_WORD_COUNT,
    parameter int SCK_HALF    = DEFAULT_SCK_HALF,
    parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  rom_loader_load,
    output logic                  rom_loader_sck,
    output logic [DATA_WIDTH-1:0] rom_loader_data,
    input  logic                  rom_loader_ack,
    output logic                  hack_external_reset,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           word_cnt
);

    localparam logic [TIMER_WIDTH-1:0]  SCK_RELOAD    = reload_value(SCK_HALF);
    localparam logic [TIMER_WIDTH-1:0]  ACK_RELOAD    = reload_value(ACK_TIMEOUT);
    localparam logic [COUNT_WIDTH:0]    WORD_TARGET   = (COUNT_WIDTH+1)'(WORD_COUNT);
    localparam logic                    EMPTY_SESSION = (WORD_COUNT == 0);

    boot_state_t            state;
    logic                   timer_load;
    logic [TIMER_WIDTH-1:0] timer_value;
    logic                   timer_expired;
    logic                   handshake;
    logic [COUNT_WIDTH:0]   next_cnt;
    logic                   more_words;

    assign handshake  = in_valid && in_ready;
    // One extra bit so the last-word comparison cannot wrap at 65535.
    assign next_cnt   = {1'b0, word_cnt} + (COUNT_WIDTH+1)'(1);
    assign more_words = (next_cnt < WORD_TARGET);

    rom_boot_timer #(
        .WIDTH      (TIMER_WIDTH)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (timer_expired)
    );

    // Restart the timer on every entry into a timed state, using the same
    // conditions that move the FSM into that state.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            FETCH: begin
                if (handshake) begin
                    timer_load  = 1'b1;
                    timer_value = SCK_RELOAD;
                end
            end
            SCK_HI: begin
                if (timer_expired) begin
                    timer_load  = 1'b1;
                    timer_value = SCK_RELOAD;
                end
            end
            SCK_LO: begin
                if (timer_expired) begin
                    timer_load  = 1'b1;
                    timer_value = ACK_RELOAD;
                end
            end
            WAIT_ACK: begin
                if (rom_loader_ack) begin
                    timer_load  = 1'b1;
                    timer_value = ACK_RELOAD;
                end
            end
            default: begin
                timer_load  = 1'b0;
                timer_value = '0;
            end
        endcase
    end

    // Session FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            in_ready            <= 1'b0;
            rom_loader_load     <= 1'b0;
            rom_loader_sck      <= 1'b0;
            rom_loader_data     <= '0;
            hack_external_reset <= 1'b1;
            done                <= 1'b0;
            error               <= 1'b0;
            word_cnt            <= '0;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (state == DONE) begin
                        hack_external_reset <= 1'b0;
                    end
                    if (start) begin
                        word_cnt            <= '0;
                        done                <= 1'b0;
                        error               <= 1'b0;
                        hack_external_reset <= 1'b1;
                        if (EMPTY_SESSION) begin
                            state           <= DONE;
                            rom_loader_load <= 1'b0;
                            done            <= 1'b1;
                        end else begin
                            state           <= FETCH;
                            rom_loader_load <= 1'b1;
                            in_ready        <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (handshake) begin
                        rom_loader_data <= in_data;
                        in_ready        <= 1'b0;
                        rom_loader_sck  <= 1'b1;
                        state           <= SCK_HI;
                    end
                end
                SCK_HI: begin
                    if (timer_expired) begin
                        rom_loader_sck <= 1'b0;
                        state          <= SCK_LO;
                    end
                end
                SCK_LO: begin
                    if (timer_expired) begin
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (rom_loader_ack) begin
                        state <= ACK_LOW;
                    end else if (timer_expired) begin
                        state           <= ERROR;
                        rom_loader_load <= 1'b0;
                        rom_loader_sck  <= 1'b0;
                        error           <= 1'b1;
                    end
                end
                ACK_LOW: begin
                    if (!rom_loader_ack) begin
                        word_cnt <= next_cnt[COUNT_WIDTH-1:0];
                        if (more_words) begin
                            state    <= FETCH;
                            in_ready <= 1'b1;
                        end else begin
                            state           <= DONE;
                            rom_loader_load <= 1'b0;
                            done            <= 1'b1;
                        end
                    end else if (timer_expired) begin
                        state           <= ERROR;
                        rom_loader_load <= 1'b0;
                        rom_loader_sck  <= 1'b0;
                        error           <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_boot_sequencer.sv
// Randomized bench for rom_boot_sequencer: a three-word loader and an
// empty-session loader share stimulus; a source driver, an ack responder and
// a negedge monitor check strobe timing, data, counts and reset behaviour.
module tb_rom_boot_sequencer;

    localparam int DW          = 16;
    localparam int WC          = 3;
    localparam int SCK_HALF    = 2;
    localparam int ACK_TIMEOUT = 16;

    logic          clk;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          ack;

    logic          a_in_ready, a_load, a_sck, a_hack, a_done, a_error;
    logic [DW-1:0] a_data;
    logic [15:0]   a_word_cnt;
    logic          b_in_ready, b_load, b_sck, b_hack, b_done, b_error;
    logic [DW-1:0] b_data;
    logic [15:0]   b_word_cnt;

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    logic [15:0] src_q[$];
    int          gap_q[$];
    logic [15:0] exp_q[$];
    logic        hs_seen = 1'b0;

    int ack_mode   = 0;
    int ack_delay  = 2;
    int ack_hold   = 2;
    int words_done = 0;

    int          rises = 0, falls = 0, hi_len = 0;
    int          fall_cyc = 0, load_fall_cyc = 0, hack_fall_cyc = 0, err_cyc = 0;
    int          b_sck_seen = 0;
    logic [15:0] cur_word = '0;
    logic        prev_sck = 0, prev_load = 0, prev_hack = 1, prev_error = 0;
    logic        prev_ready = 0, prev_hs = 0;

    rom_boot_sequencer #(
        .DATA_WIDTH (DW), .WORD_COUNT (WC), .SCK_HALF (SCK_HALF), .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut_a (
        .clk (clk), .reset (reset), .start (start), .in_valid (in_valid), .in_data (in_data),
        .in_ready (a_in_ready), .rom_loader_load (a_load), .rom_loader_sck (a_sck),
        .rom_loader_data (a_data), .rom_loader_ack (ack), .hack_external_reset (a_hack),
        .done (a_done), .error (a_error), .word_cnt (a_word_cnt)
    );

    rom_boot_sequencer #(
        .DATA_WIDTH (DW), .WORD_COUNT (0), .SCK_HALF (SCK_HALF), .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut_b (
        .clk (clk), .reset (reset), .start (start), .in_valid (in_valid), .in_data (in_data),
        .in_ready (b_in_ready), .rom_loader_load (b_load), .rom_loader_sck (b_sck),
        .rom_loader_data (b_data), .rom_loader_ack (ack), .hack_external_reset (b_hack),
        .done (b_done), .error (b_error), .word_cnt (b_word_cnt)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%0h required 0x%0h at cycle %0d", tag, actual, expected, cyc);
        end
    endtask

    task automatic push_word(input logic [15:0] w, input int gap);
        src_q.push_back(w);
        gap_q.push_back(gap);
        exp_q.push_back(w);
    endtask

    // Source: waits the requested gap, offers the word, drops it after the handshake.
    initial begin
        int gap_cnt;
        gap_cnt  = 0;
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                in_valid = 1'b0;
                gap_cnt  = 0;
            end else if (in_valid) begin
                if (hs_seen) begin
                    in_valid = 1'b0;
                    void'(src_q.pop_front());
                    void'(gap_q.pop_front());
                    gap_cnt = 0;
                end
            end else if (src_q.size() > 0) begin
                if (gap_cnt < gap_q[0]) begin
                    gap_cnt++;
                end else begin
                    in_valid = 1'b1;
                    in_data  = src_q[0];
                end
            end
        end
    end

    // SoC ack model: raises ack ack_delay cycles after the ack wait begins, holds it ack_hold cycles.
    initial begin
        int  dly;
        int  hold;
        logic ps;
        dly  = 0;
        hold = 0;
        ps   = 1'b0;
        ack  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                ack  = 1'b0;
                dly  = 0;
                hold = 0;
                ps   = 1'b0;
            end else begin
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) begin
                        ack = 1'b0;
                        words_done++;
                    end
                end else if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        ack  = 1'b1;
                        hold = ack_hold;
                    end
                end
                if (ps && !a_sck && ack_mode == 0) begin
                    dly = SCK_HALF + ack_delay;
                end
                ps = a_sck;
            end
        end
    end

    // Monitor: strobe widths, data per strobe, counts, ready hold and event timestamps.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (a_sck && !prev_sck) begin
                rises++;
                hi_len = 1;
                check_output("word_available", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    cur_word = exp_q.pop_front();
                    check_output("sck_data", 32'(a_data), 32'(cur_word));
                end
                check_output("cnt_at_sck", 32'(a_word_cnt), 32'(words_done));
            end else if (a_sck) begin
                hi_len++;
                check_output("data_stable", 32'(a_data), 32'(cur_word));
            end
            if (!a_sck && prev_sck) begin
                falls++;
                fall_cyc = cyc;
                check_output("sck_hi_len", 32'(hi_len), 32'(SCK_HALF));
            end
            if (a_sck) begin
                check_output("sck_outside_fetch", 32'(a_in_ready), 32'd0);
            end
            if (prev_ready && !prev_hs) begin
                check_output("ready_held", 32'(a_in_ready), 32'd1);
            end
            if (prev_load && !a_load) load_fall_cyc = cyc;
            if (prev_hack && !a_hack) hack_fall_cyc = cyc;
            if (a_error && !prev_error) err_cyc = cyc;
        end
        if (b_sck) b_sck_seen++;
        hs_seen    = in_valid && a_in_ready && !reset;
        prev_hs    = hs_seen;
        prev_sck   = a_sck;
        prev_load  = a_load;
        prev_hack  = a_hack;
        prev_error = a_error;
        prev_ready = a_in_ready;
    end

    // Pulse start for one cycle and check both loaders react to it.
    task automatic apply_stimulus();
        @(posedge clk); #1;
        start      = 1'b1;
        words_done = 0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        check_output("start_load", 32'(a_load), 32'd1);
        check_output("start_hack", 32'(a_hack), 32'd1);
        check_output("start_error_clr", 32'(a_error), 32'd0);
        check_output("start_done_clr", 32'(a_done), 32'd0);
        check_output("start_cnt_clr", 32'(a_word_cnt), 32'd0);
        check_output("start_ready", 32'(a_in_ready), 32'd1);
        check_output("empty_done", 32'(b_done), 32'd1);
        check_output("empty_load", 32'(b_load), 32'd0);
        check_output("empty_hack_held", 32'(b_hack), 32'd1);
        @(negedge clk); #1;
        check_output("empty_hack_release", 32'(b_hack), 32'd0);
        check_output("empty_done_level", 32'(b_done), 32'd1);
    endtask

    // Wait for the session to end and check the completed-load outcome.
    task automatic finish_session(input int rise0);
        int guard;
        guard = 0;
        while (!(a_done || a_error) && guard < 3000) begin
            @(negedge clk); #1;
            guard++;
        end
        check_output("session_end", 32'(a_done), 32'd1);
        check_output("end_error", 32'(a_error), 32'd0);
        check_output("end_cnt", 32'(a_word_cnt), 32'(WC));
        check_output("end_load", 32'(a_load), 32'd0);
        check_output("end_strobes", 32'(rises - rise0), 32'(WC));
        check_output("end_words_left", 32'(exp_q.size()), 32'd0);
        @(negedge clk); #1;
        @(negedge clk); #1;
        check_output("end_hack", 32'(a_hack), 32'd0);
        check_output("hack_lag", 32'(hack_fall_cyc - load_fall_cyc), 32'd1);
        check_output("done_level", 32'(a_done), 32'd1);
    endtask

    initial begin
        int   r0;
        int   n;
        int   guard;
        logic ps;

        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_output("rst_ready", 32'(a_in_ready), 32'd0);
        check_output("rst_load", 32'(a_load), 32'd0);
        check_output("rst_sck", 32'(a_sck), 32'd0);
        check_output("rst_data", 32'(a_data), 32'd0);
        check_output("rst_hack", 32'(a_hack), 32'd1);
        check_output("rst_done", 32'(a_done), 32'd0);
        check_output("rst_error", 32'(a_error), 32'd0);
        check_output("rst_cnt", 32'(a_word_cnt), 32'd0);
        check_output("rst_b_hack", 32'(b_hack), 32'd1);
        check_output("rst_b_done", 32'(b_done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check_output("idle_ready", 32'(a_in_ready), 32'd0);
        check_output("idle_hack", 32'(a_hack), 32'd1);

        $display("[TB] three fixed words, 2-cycle ack");
        push_word(16'h1234, 0);
        push_word(16'hABCD, 1);
        push_word(16'h0000, 0);
        r0 = rises;
        apply_stimulus();
        finish_session(r0);

        $display("[TB] 10-cycle source gaps");
        for (int i = 0; i < WC; i++) push_word(16'($urandom), 10);
        r0 = rises;
        apply_stimulus();
        finish_session(r0);

        $display("[TB] ack stuck low");
        ack_mode = 1;
        push_word(16'($urandom), 0);
        apply_stimulus();
        guard = 0;
        while (!a_error && guard < 500) begin
            @(negedge clk); #1;
            guard++;
        end
        check_output("timeout_error", 32'(a_error), 32'd1);
        check_output("timeout_latency", 32'(err_cyc - fall_cyc), 32'(SCK_HALF + ACK_TIMEOUT));
        check_output("timeout_load", 32'(a_load), 32'd0);
        check_output("timeout_sck", 32'(a_sck), 32'd0);
        check_output("timeout_cnt", 32'(a_word_cnt), 32'd0);
        check_output("timeout_done", 32'(a_done), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check_output("timeout_hack", 32'(a_hack), 32'd1);
        check_output("timeout_error_level", 32'(a_error), 32'd1);
        ack_mode = 0;

        $display("[TB] start pulsed while waiting for ack");
        for (int i = 0; i < WC; i++) push_word(16'($urandom), 0);
        r0 = rises;
        apply_stimulus();
        guard = 0;
        while (!a_sck && guard < 200) begin @(posedge clk); #1; guard++; end
        while (a_sck && guard < 200) begin @(posedge clk); #1; guard++; end
        @(posedge clk);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        check_output("ignored_start_ready", 32'(a_in_ready), 32'd0);
        check_output("ignored_start_load", 32'(a_load), 32'd1);
        finish_session(r0);

        $display("[TB] reset during second strobe");
        push_word(16'($urandom), 0);
        push_word(16'($urandom), 0);
        push_word(16'($urandom), 0);
        apply_stimulus();
        n     = 0;
        guard = 0;
        ps    = 1'b0;
        while (n < 2 && guard < 500) begin
            @(posedge clk); #1;
            if (a_sck && !ps) n++;
            ps = a_sck;
            guard++;
        end
        check_output("reach_word2", 32'(n), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check_output("mid_rst_ready", 32'(a_in_ready), 32'd0);
        check_output("mid_rst_load", 32'(a_load), 32'd0);
        check_output("mid_rst_sck", 32'(a_sck), 32'd0);
        check_output("mid_rst_data", 32'(a_data), 32'd0);
        check_output("mid_rst_hack", 32'(a_hack), 32'd1);
        check_output("mid_rst_done", 32'(a_done), 32'd0);
        check_output("mid_rst_error", 32'(a_error), 32'd0);
        check_output("mid_rst_cnt", 32'(a_word_cnt), 32'd0);
        src_q.delete();
        gap_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check_output("no_resume_ready", 32'(a_in_ready), 32'd0);
        check_output("no_resume_load", 32'(a_load), 32'd0);
        check_output("no_resume_hack", 32'(a_hack), 32'd1);
        for (int i = 0; i < WC; i++) push_word(16'($urandom), 0);
        r0 = rises;
        apply_stimulus();
        finish_session(r0);

        $display("[TB] randomized sessions");
        for (int s = 0; s < 3; s++) begin
            ack_delay = $urandom_range(0, 5);
            ack_hold  = $urandom_range(1, 3);
            for (int i = 0; i < WC; i++) push_word(16'($urandom), $urandom_range(0, 4));
            r0 = rises;
            apply_stimulus();
            finish_session(r0);
        end

        check_output("empty_never_sck", 32'(b_sck_seen), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
